// File: rtl/dmem_port_arbiter_if.sv
// rtl/dmem_port_arbiter_if.sv - request/response and memory-side bus of the data-memory port arbiter
interface dmem_port_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   logic [1:0]          req_valid;
   logic [1:0]          req_ready;
   logic [1:0]          req_we;
   logic [3:0]          req_size;
   logic [1:0]          req_signed;
   logic [2*ADDR_W-1:0] req_addr;
   logic [2*DATA_W-1:0] req_wdata;
   logic [1:0]          rsp_valid;
   logic                rsp_err;
   logic [DATA_W-1:0]   rsp_rdata;
   logic                mem_write_en;
   logic                mem_read_en;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_data_input;
   logic [1:0]          store_format;
   logic [2:0]          load_format;
   logic [DATA_W-1:0]   mem_data_output;

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_data_output,
      output req_ready, rsp_valid, rsp_err, rsp_rdata,
      output mem_write_en, mem_read_en, mem_addr, mem_data_input, store_format, load_format
   );

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_data_output,
      input  req_ready, rsp_valid, rsp_err, rsp_rdata,
      input  mem_write_en, mem_read_en, mem_addr, mem_data_input, store_format, load_format
   );
endinterface

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - round-robin two-port arbiter and sequencer for the 4096 x 8 data memory
// Define DMEM_ARB_ALIGN_CHECK_EN to reject misaligned accesses with rsp_err.
module dmem_port_arbiter #(
   parameter int ADDR_W    = 64,
   parameter int DATA_W    = 64,
   parameter int MEM_BYTES = 4096
) (
   input logic                clk,
   input logic                reset,
   dmem_port_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

   state_t            state, state_nxt;
   logic              rr_ptr, grant, grant_sel, accept;
   logic              l_we, l_signed, l_err;
   logic [1:0]        l_size;
   logic              sel_we, sel_signed, sel_err, out_of_range, misaligned;
   logic [1:0]        sel_size;
   logic [3:0]        sel_bytes;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [ADDR_W:0]   end_addr;

   function automatic logic [2:0] load_code(input logic [1:0] sz);
      logic [2:0] c;
      case (sz)
         2'b00:   c = 3'b000;
         2'b01:   c = 3'b001;
         2'b10:   c = 3'b010;
         default: c = 3'b101;
      endcase
      return c;
   endfunction

   function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] d, input logic [1:0] sz,
                                                input logic sg);
      logic [DATA_W-1:0] r;
      case (sz)
         2'b00:   r = {{(DATA_W-8){sg & d[7]}}, d[7:0]};
         2'b01:   r = {{(DATA_W-16){sg & d[15]}}, d[15:0]};
         2'b10:   r = {{(DATA_W-32){sg & d[31]}}, d[31:0]};
         default: r = d;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|bus.req_valid) state_nxt = ACCESS;
         ACCESS:  state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      grant_sel     = (bus.req_valid == 2'b11) ? rr_ptr : ~bus.req_valid[0];
      accept        = (state == IDLE) && (|bus.req_valid);
      bus.req_ready = 2'b00;
      if (accept && !reset) bus.req_ready = grant_sel ? 2'b10 : 2'b01;
   end

   // The extra top bit of end_addr catches address wrap as out of range.
   always_comb begin
      sel_we       = grant_sel ? bus.req_we[1]     : bus.req_we[0];
      sel_signed   = grant_sel ? bus.req_signed[1] : bus.req_signed[0];
      sel_size     = grant_sel ? bus.req_size[3:2] : bus.req_size[1:0];
      sel_addr     = grant_sel ? bus.req_addr[2*ADDR_W-1:ADDR_W]  : bus.req_addr[ADDR_W-1:0];
      sel_wdata    = grant_sel ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];
      sel_bytes    = 4'd1 << sel_size;
      end_addr     = {1'b0, sel_addr} + (ADDR_W+1)'(sel_bytes);
      out_of_range = end_addr > (ADDR_W+1)'(MEM_BYTES);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      misaligned   = |(sel_addr[2:0] & (sel_bytes[2:0] - 3'd1));
`else
      misaligned   = 1'b0;
`endif
      sel_err      = out_of_range | misaligned;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr             <= 1'b0;
         grant              <= 1'b0;
         l_we               <= 1'b0;
         l_signed           <= 1'b0;
         l_err              <= 1'b0;
         l_size             <= 2'b00;
         bus.mem_write_en   <= 1'b0;
         bus.mem_read_en    <= 1'b0;
         bus.mem_addr       <= '0;
         bus.mem_data_input <= '0;
         bus.store_format   <= 2'b00;
         bus.load_format    <= 3'b000;
         bus.rsp_valid      <= 2'b00;
         bus.rsp_err        <= 1'b0;
         bus.rsp_rdata      <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               grant            <= grant_sel;
               rr_ptr           <= ~grant_sel;
               l_we             <= sel_we;
               l_signed         <= sel_signed;
               l_size           <= sel_size;
               l_err            <= sel_err;
               bus.mem_write_en <= !sel_err && sel_we;
               bus.mem_read_en  <= !sel_err && !sel_we;
               if (!sel_err) begin
                  bus.mem_addr       <= sel_addr;
                  bus.mem_data_input <= sel_wdata;
                  bus.store_format   <= sel_size;
                  bus.load_format    <= load_code(sel_size);
               end
            end
            ACCESS: begin
               bus.mem_write_en <= 1'b0;
               bus.mem_read_en  <= 1'b0;
               bus.rsp_valid    <= grant ? 2'b10 : 2'b01;
               bus.rsp_err      <= l_err;
               bus.rsp_rdata    <= (l_we || l_err) ? '0 : extend(bus.mem_data_output, l_size, l_signed);
            end
            default: begin
               bus.rsp_valid <= 2'b00;
               bus.rsp_err   <= 1'b0;
               bus.rsp_rdata <= '0;
            end
         endcase
      end
   end
endmodule
